// File: rtl/reaction_timer_if.sv
// Player/score-row side of the reaction timer: trial controls in, stimulus and score-row write out.
interface reaction_timer_if #(
  parameter int WIDTH    = 13,
  parameter int ROW_BITS = 2
);
  logic                start;
  logic                react;
  logic                stimulus;
  logic [WIDTH-1:0]    result;
  logic                load;
  logic [ROW_BITS-1:0] row_sel;
  logic                busy;
  logic                false_start;
  logic                timeout;

  modport master (
    output start, react,
    input  stimulus, result, load, row_sel, busy, false_start, timeout
  );

  modport slave (
    input  start, react,
    output stimulus, result, load, row_sel, busy, false_start, timeout
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction trial timer feeding the score rows; Load follows a sampled React by one cycle.
// No backpressure: every write is a single-cycle strobe the score row must accept.
module reaction_timer #(
  parameter int CLK_PER_MS   = 50000,
  parameter int WIDTH        = 13,
  parameter int MIN_DELAY_MS = 1000,
  parameter int ROWS         = 4,
  parameter int ROW_BITS     = 2
) (
  input  logic             clk,
  input  logic             rst,
  reaction_timer_if.slave  bus
);

  localparam int PS_W  = $clog2(CLK_PER_MS);
  localparam int DLY_W = $clog2(MIN_DELAY_MS + 2048);
  localparam int CNT_W = (DLY_W > WIDTH) ? DLY_W : WIDTH;
  localparam logic [WIDTH-1:0] MAX_RES = '1;

  typedef enum logic [2:0] {IDLE, DELAY, ARMED, WRITE, FAULT} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [PS_W-1:0]     presc;
  logic [CNT_W-1:0]    ms_cnt;
  logic [DLY_W-1:0]    target;
  logic [ROW_BITS-1:0] row_ptr;
  logic                stimulus_q;
  logic [WIDTH-1:0]    result_q;
  logic                load_q;
  logic                busy_q;
  logic                false_start_q;
  logic                timeout_q;

  logic             tick;
  logic [CNT_W-1:0] ms_nxt;

  assign tick   = (presc == PS_W'(CLK_PER_MS - 1));
  assign ms_nxt = ms_cnt + CNT_W'(1);

  // Free-running in every state so the delay depends on when Start arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      presc         <= '0;
      ms_cnt        <= '0;
      target        <= '0;
      row_ptr       <= '0;
      stimulus_q    <= 1'b0;
      result_q      <= '0;
      load_q        <= 1'b0;
      busy_q        <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= DELAY;
            busy_q        <= 1'b1;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            target        <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[10:0]);
            ms_cnt        <= '0;
            presc         <= '0;
          end
        end
        DELAY: begin
          if (bus.react) begin
            state         <= FAULT;
            false_start_q <= 1'b1;
          end else if (tick) begin
            if (ms_nxt == CNT_W'(target)) begin
              state      <= ARMED;
              stimulus_q <= 1'b1;
              ms_cnt     <= '0;
              presc      <= '0;
            end else begin
              ms_cnt <= ms_nxt;
            end
          end
        end
        ARMED: begin
          // React wins over a tick in the same cycle: report the pre-tick count.
          if (bus.react) begin
            state      <= WRITE;
            result_q   <= ms_cnt[WIDTH-1:0];
            load_q     <= 1'b1;
            stimulus_q <= 1'b0;
          end else if (tick) begin
            ms_cnt <= ms_nxt;
            if (ms_nxt == CNT_W'(MAX_RES)) begin
              state      <= WRITE;
              result_q   <= MAX_RES;
              timeout_q  <= 1'b1;
              load_q     <= 1'b1;
              stimulus_q <= 1'b0;
            end
          end
        end
        WRITE: begin
          state   <= IDLE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          row_ptr <= (row_ptr == ROW_BITS'(ROWS - 1)) ? '0 : row_ptr + ROW_BITS'(1);
        end
        FAULT: begin
          if (!bus.react) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          load_q     <= 1'b0;
          stimulus_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stimulus    = stimulus_q;
  assign bus.result      = result_q;
  assign bus.load        = load_q;
  assign bus.row_sel     = row_ptr;
  assign bus.busy        = busy_q;
  assign bus.false_start = false_start_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Measurement stage directly upstream of the 13-bit score register row.
- Runs one reaction trial per Start pulse: waits a pseudo-random delay, lights the stimulus, then counts milliseconds until React.
- Presents the result with a one-cycle Load strobe and a row select, so each trial lands in the next row of the score register file.
- Also detects false starts and timeouts.

Parameters:
CLK_PER_MS, 50000, Clock cycles per millisecond tick (≥2)
WIDTH, 13, result width in ms; saturates at 2^WIDTH-1 = 8191
MIN_DELAY_MS, 1000, minimum stimulus delay in ms
ROWS, 4, number of score rows written round-robin
ROW_BITS, 2, width of RowSel, ≥ clog2(ROWS)

Ports:
Clock  in  1  system clock, all logic rising-edge
Reset  in  1  asynchronous, active-high; clears all state immediately
Start  in  1  synchronous, debounced, single-cycle trial request
React  in  1  synchronous, debounced player button level
Stimulus  out  1  registered; high while waiting for the player's reaction
Result  out  WIDTH  measured ms, held between writes
Load  out  1  one-cycle write strobe to the score register row
RowSel  out  ROW_BITS  target row for the current Load
Busy  out  1  high in any state other than IDLE
FalseStart  out  1  sticky; set on early React, cleared by next accepted Start
Timeout  out  1  sticky; set on saturation, cleared by next accepted Start

Behaviour:
- Reset values:
  - Outputs: Stimulus=0, Result=0, Load=0, RowSel=0, Busy=0, FalseStart=0, Timeout=0.
  - Internal: state=IDLE, prescaler=0, ms counter=0, row pointer=0, LFSR=16'hACE1.
- Reset mid-trial aborts with no Load.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every Clock cycle in all states and is never zero.
- Prescaler: counts 0..CLK_PER_MS-1. A ms tick is generated when it reaches CLK_PER_MS-1. It is zeroed on entry to DELAY and on entry to ARMED, so the first tick comes exactly CLK_PER_MS cycles after entry.
- IDLE:
  - Start=1 → DELAY. Clear FalseStart and Timeout.
  - Latch delay target = MIN_DELAY_MS + LFSR[10:0] (range MIN..MIN+2047 ms).
- DELAY:
  - Counts ms ticks up to the delay target.
  - React=1 on any cycle, including the first cycle after Start → FAULT. Covers React held through Start.
  - When the tick count equals the target, in the same cycle as the tick → ARMED. Set Stimulus=1 and zero the ms counter.
- ARMED:
  - Each tick increments the ms counter.
  - React=1 → WRITE with Result = counter value before any tick in that cycle. Simultaneous tick is ignored.
  - If the counter reaches 2^WIDTH-1 with no React → WRITE with Result=2^WIDTH-1 and Timeout=1.
  - Stimulus falls on exit from ARMED.
- WRITE (exactly one cycle):
  - Load=1 and RowSel=row pointer; Result is already stable on this cycle.
  - Row pointer then increments, wrapping ROWS-1 → 0.
  - → IDLE.
  - Latency: React sampled high in cycle N of ARMED → Load high in cycle N+1.
- FAULT:
  - FalseStart=1, Stimulus=0, no Load, Result unchanged, row pointer unchanged.
  - Waits for React=0 → IDLE.
- Start is ignored in every state except IDLE. A Start coinciding with the WRITE cycle is dropped.
- Load never asserts on two consecutive cycles. RowSel changes only on the cycle after a Load.
- Result width rule: the counter is WIDTH bits, saturating, never wraps.

Test Plan:
- Normal trial (CLK_PER_MS=4, MIN_DELAY_MS=2):
  - Reset, Start → Stimulus rises after (2+LFSR[10:0])×4 cycles.
  - React after 37 ms of ticks → Load for 1 cycle with Result=37, RowSel=0, Busy falls the next cycle.
- False start: React=1 during DELAY → FalseStart=1, no Load ever.
  - Hold React 10 cycles, stay in FAULT; release → IDLE.
  - Next Start clears FalseStart.
- Timeout (WIDTH=4 override): no React → Result=15, Timeout=1, single Load. The counter does not wrap to 0.
- Row wrap: 5 consecutive valid trials → RowSel sequence 0,1,2,3,0, each with exactly one Load pulse.
- Boundary/simultaneity:
  - React on the same cycle as a ms tick at count 5 → Result=5.
  - Start pulses during DELAY/ARMED → ignored, no trial restart.
- Async reset mid-ARMED: assert Reset between edges → outputs are zero immediately, no Load, and the next trial writes RowSel=0.
